// File: rtl/systolic_bn_seq_if.sv
// Bus bundle between the job/array/BN environment and the systolic BN sequencer.
interface systolic_bn_seq_if #(
  parameter int PE_ROW_NUM = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MB_W       = 2
);
  logic                  job_valid;
  logic                  job_ready;
  logic [DATA_WIDTH-1:0] job_gamma;
  logic [DATA_WIDTH-1:0] job_beta;
  logic                  abort;
  logic                  start;
  logic                  cal_done;
  logic [PE_ROW_NUM-1:0] valid_x_out;
  logic [1:0]            mode_out;
  logic [DATA_WIDTH-1:0] gamma_out;
  logic [DATA_WIDTH-1:0] beta_out;
  logic                  valid_gamma_beta;
  logic                  busy;
  logic [MB_W-1:0]       mb_idx;
  logic                  done;
  logic                  err_timeout;
  logic                  err_skew;

  // Environment side: issues jobs, runs the array and the BN engines.
  modport master (
    output job_valid, job_gamma, job_beta, abort, cal_done, valid_x_out,
    input  job_ready, start, mode_out, gamma_out, beta_out, valid_gamma_beta,
           busy, mb_idx, done, err_timeout, err_skew
  );

  // Sequencer side.
  modport slave (
    input  job_valid, job_gamma, job_beta, abort, cal_done, valid_x_out,
    output job_ready, start, mode_out, gamma_out, beta_out, valid_gamma_beta,
           busy, mb_idx, done, err_timeout, err_skew
  );
endinterface

// File: rtl/systolic_bn_seq.sv
// Job-level sequencer: loads gamma/beta, issues one array start per sample,
// switches the BN engines to normalize after each mini-batch and drains them.
module systolic_bn_seq #(
  parameter int PE_ROW_NUM  = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int MINI_BATCH  = 8,
  parameter int TOTAL_BATCH = 16,
  parameter int TIMEOUT     = 1024
) (
  input logic              clk,
  input logic              rst_n,
  systolic_bn_seq_if.slave bus
);
  localparam int NMB  = TOTAL_BATCH / MINI_BATCH;
  localparam int MB_W = $clog2(NMB + 1);
  localparam int CW   = $clog2(MINI_BATCH + 1);
  localparam int WD_W = $clog2(TIMEOUT);

  localparam logic [CW-1:0]   CNT_LAST = CW'(MINI_BATCH - 1);
  localparam logic [MB_W-1:0] MB_LAST  = MB_W'(NMB - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_CAL, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         samp_cnt, out_cnt;
  logic [WD_W-1:0]       wdog;
  logic [MB_W-1:0]       mb_idx_q;
  logic [DATA_WIDTH-1:0] gamma_q, beta_q;
  logic                  err_timeout_q, err_skew_q;

  logic all_ones, skew, wd_exp, last_mb, accept;

  // Row agreement: all rows valid is a counted output, a partial set is skew.
  assign all_ones = &bus.valid_x_out;
  assign skew     = (|bus.valid_x_out) & ~all_ones;
  assign wd_exp   = (wdog == WD_LAST);
  assign last_mb  = (mb_idx_q == MB_LAST);
  assign accept   = (state == IDLE) & bus.job_valid & ~bus.abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.job_valid) state_nxt = LOAD;
      LOAD:     state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_CAL;
      WAIT_CAL: begin
        if (bus.cal_done)  state_nxt = (samp_cnt == CNT_LAST) ? DRAIN : ISSUE;
        else if (wd_exp)   state_nxt = IDLE;
      end
      DRAIN: begin
        if (all_ones) begin
          if (out_cnt == CNT_LAST) state_nxt = last_mb ? DONE : ISSUE;
        end else if (wd_exp) begin
          state_nxt = IDLE;
        end
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;
  end

  // Output decode from the current state.
  always_comb begin
    bus.start            = 1'b0;
    bus.valid_gamma_beta = 1'b0;
    bus.done             = 1'b0;
    bus.mode_out         = 2'b00;
    case (state)
      LOAD:     begin bus.valid_gamma_beta = 1'b1; bus.mode_out = 2'b01; end
      ISSUE:    begin bus.start = 1'b1;            bus.mode_out = 2'b01; end
      WAIT_CAL: bus.mode_out = 2'b01;
      DRAIN:    bus.mode_out = 2'b10;
      DONE:     bus.done = 1'b1;
      default:  ;
    endcase
  end

  // Job parameters, counters, watchdog and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gamma_q       <= '0;
      beta_q        <= '0;
      samp_cnt      <= '0;
      out_cnt       <= '0;
      mb_idx_q      <= '0;
      wdog          <= '0;
      err_timeout_q <= 1'b0;
      err_skew_q    <= 1'b0;
    end else if (accept) begin
      gamma_q       <= bus.job_gamma;
      beta_q        <= bus.job_beta;
      samp_cnt      <= '0;
      out_cnt       <= '0;
      mb_idx_q      <= '0;
      err_timeout_q <= 1'b0;
      err_skew_q    <= 1'b0;
    end else if (!bus.abort) begin
      case (state)
        ISSUE: wdog <= '0;
        WAIT_CAL: begin
          if (bus.cal_done) begin
            samp_cnt <= samp_cnt + CW'(1);
            wdog     <= '0;
          end else if (wd_exp) begin
            err_timeout_q <= 1'b1;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        DRAIN: begin
          if (all_ones) begin
            wdog <= '0;
            if (out_cnt == CNT_LAST && !last_mb) begin
              mb_idx_q <= mb_idx_q + MB_W'(1);
              samp_cnt <= '0;
              out_cnt  <= '0;
            end else begin
              out_cnt <= out_cnt + CW'(1);
            end
          end else begin
            if (skew) err_skew_q <= 1'b1;
            if (wd_exp) err_timeout_q <= 1'b1;
            else        wdog <= wdog + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.job_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.gamma_out   = gamma_q;
  assign bus.beta_out    = beta_q;
  assign bus.mb_idx      = mb_idx_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_skew    = err_skew_q;
endmodule

// File: tb/tb_systolic_bn_seq.sv
// Directed testbench for the systolic BN sequencer (default parameters).
module tb_systolic_bn_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  systolic_bn_seq_if #(.PE_ROW_NUM(4), .DATA_WIDTH(16), .MB_W(2)) bus();

  systolic_bn_seq #(
    .PE_ROW_NUM(4), .DATA_WIDTH(16), .MINI_BATCH(8), .TOTAL_BATCH(16), .TIMEOUT(1024)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n_start; int fs; int d0; int d1; int r1; int done_k; int n_done; int vgb_k; int es_k;
    logic [1:0] mb0; logic [1:0] mb1; logic [1:0] m_load;
    logic [15:0] g; logic [15:0] b; logic et_load;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full job with cal_done 5 cycles after each start and 8 all-ones
  // drain cycles; optionally prefixes the first drain with one skewed cycle.
  // Cycle numbers are relative to the accept cycle T (k=0).
  task automatic run_job(input logic [15:0] g, input logic [15:0] b, input bit skew_first,
                         output obs_t o);
    int cal_due, dstart, ndr, off;
    logic [1:0] pmode;
    o = '{n_start:0, fs:-1, d0:-1, d1:-1, r1:-1, done_k:-1, n_done:0, vgb_k:-1, es_k:-1,
          mb0:2'b11, mb1:2'b11, m_load:2'b11, g:16'h0, b:16'h0, et_load:1'bx};
    cal_due = -1; dstart = 0; ndr = 0;
    bus.job_gamma = g; bus.job_beta = b; bus.job_valid = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    pmode = 2'b00;
    for (int k = 1; k < 400 && o.done_k < 0; k++) begin
      if (bus.valid_gamma_beta && o.vgb_k < 0) begin
        o.vgb_k = k; o.g = bus.gamma_out; o.b = bus.beta_out;
        o.m_load = bus.mode_out; o.et_load = bus.err_timeout;
      end
      if (bus.start) begin
        o.n_start++; cal_due = k + 5;
        if (o.fs < 0) o.fs = k;
      end
      if (bus.done) begin o.n_done++; o.done_k = k; end
      if (bus.err_skew && o.es_k < 0) o.es_k = k;
      if (bus.mode_out == 2'b10 && pmode != 2'b10) begin
        dstart = k; ndr++;
        if (ndr == 1) begin o.d0 = k; o.mb0 = bus.mb_idx; end
        else          begin o.d1 = k; o.mb1 = bus.mb_idx; end
      end
      if (bus.mode_out == 2'b01 && pmode == 2'b10 && o.r1 < 0) o.r1 = k;
      pmode = bus.mode_out;
      bus.cal_done = (k == cal_due);
      off = k - dstart;
      if (bus.mode_out != 2'b10)        bus.valid_x_out = 4'h0;
      else if (skew_first && ndr == 1)  bus.valid_x_out = (off == 0) ? 4'b0111 : ((off <= 8) ? 4'hF : 4'h0);
      else                              bus.valid_x_out = (off < 8) ? 4'hF : 4'h0;
      tick();
    end
    bus.cal_done = 1'b0;
    bus.valid_x_out = 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.job_valid = 0; bus.job_gamma = 0; bus.job_beta = 0;
    bus.abort = 0; bus.cal_done = 0; bus.valid_x_out = 0;
    tick(); tick();
    checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", bus.start); end
    checks++; if (bus.valid_gamma_beta !== 1'b0) begin errors++; $display("FAIL reset_vgb got=%b exp=0", bus.valid_gamma_beta); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.mode_out !== 2'b00) begin errors++; $display("FAIL reset_mode got=%b exp=00", bus.mode_out); end
    checks++; if (bus.gamma_out !== 16'h0 || bus.beta_out !== 16'h0) begin errors++; $display("FAIL reset_gb got=%h/%h exp=0/0", bus.gamma_out, bus.beta_out); end
    checks++; if (bus.mb_idx !== 2'd0) begin errors++; $display("FAIL reset_mb got=%0d exp=0", bus.mb_idx); end
    checks++; if (bus.err_timeout !== 1'b0 || bus.err_skew !== 1'b0) begin errors++; $display("FAIL reset_err got=%b%b exp=00", bus.err_timeout, bus.err_skew); end
    checks++; if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b/%b exp=1/0", bus.job_ready, bus.busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_job();
    obs_t o;
    run_job(16'h3C00, 16'h0010, 1'b0, o);
    checks++; if (o.vgb_k !== 1) begin errors++; $display("FAIL full_vgb_cycle got=%0d exp=1", o.vgb_k); end
    checks++; if (o.g !== 16'h3C00 || o.b !== 16'h0010) begin errors++; $display("FAIL full_gb got=%h/%h exp=3c00/0010", o.g, o.b); end
    checks++; if (o.m_load !== 2'b01) begin errors++; $display("FAIL full_mode_load got=%b exp=01", o.m_load); end
    checks++; if (o.fs !== 2) begin errors++; $display("FAIL full_first_start got=%0d exp=2", o.fs); end
    checks++; if (o.n_start !== 16) begin errors++; $display("FAIL full_starts got=%0d exp=16", o.n_start); end
    checks++; if (o.d0 !== 50 || o.mb0 !== 2'd0) begin errors++; $display("FAIL full_drain0 got=%0d/mb%0d exp=50/mb0", o.d0, o.mb0); end
    checks++; if (o.r1 !== 58) begin errors++; $display("FAIL full_back_to_stats got=%0d exp=58", o.r1); end
    checks++; if (o.d1 !== 106 || o.mb1 !== 2'd1) begin errors++; $display("FAIL full_drain1 got=%0d/mb%0d exp=106/mb1", o.d1, o.mb1); end
    checks++; if (o.done_k !== 114 || o.n_done !== 1) begin errors++; $display("FAIL full_done got=%0d x%0d exp=114 x1", o.done_k, o.n_done); end
    checks++; if (bus.job_ready !== 1'b1 || bus.mode_out !== 2'b00) begin errors++; $display("FAIL full_idle got=%b/%b exp=1/00", bus.job_ready, bus.mode_out); end
    checks++; if (bus.gamma_out !== 16'h3C00 || bus.err_skew !== 1'b0) begin errors++; $display("FAIL full_hold got=%h/%b exp=3c00/0", bus.gamma_out, bus.err_skew); end
  endtask

  task automatic test_cal_held();
    int n_start, odd, pre_drain, d0, done_k;
    n_start = 0; odd = 0; pre_drain = -1; d0 = -1; done_k = -1;
    bus.job_gamma = 16'h1111; bus.job_beta = 16'h2222;
    bus.job_valid = 1'b1; bus.cal_done = 1'b1; bus.valid_x_out = 4'hF;
    tick();
    bus.job_valid = 1'b0;
    for (int k = 1; k < 120 && done_k < 0; k++) begin
      if (bus.start) begin n_start++; if (k % 2 != 0) odd++; end
      if (bus.mode_out == 2'b10 && d0 < 0) begin d0 = k; pre_drain = n_start; end
      if (bus.done) done_k = k;
      tick();
    end
    bus.cal_done = 1'b0; bus.valid_x_out = 4'h0;
    checks++; if (pre_drain !== 8 || d0 !== 18) begin errors++; $display("FAIL held_pre_drain got=%0d@%0d exp=8@18", pre_drain, d0); end
    checks++; if (odd !== 0) begin errors++; $display("FAIL held_alternate got=%0d odd starts exp=0", odd); end
    checks++; if (n_start !== 16 || done_k !== 50) begin errors++; $display("FAIL held_done got=%0d starts done@%0d exp=16 done@50", n_start, done_k); end
    checks++; if (bus.err_skew !== 1'b0) begin errors++; $display("FAIL held_no_skew got=%b exp=0", bus.err_skew); end
  endtask

  task automatic test_timeout();
    int et_k, n_start, n_done;
    et_k = -1; n_start = 0; n_done = 0;
    bus.job_gamma = 16'h0A0A; bus.job_beta = 16'h0B0B; bus.job_valid = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    for (int k = 1; k < 1100 && et_k < 0; k++) begin
      if (bus.start) n_start++;
      if (bus.done) n_done++;
      if (bus.err_timeout) et_k = k;
      if (et_k < 0) tick();
    end
    checks++; if (et_k !== 1027) begin errors++; $display("FAIL timeout_cycle got=%0d exp=1027", et_k); end
    checks++; if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0 || bus.mode_out !== 2'b00) begin errors++; $display("FAIL timeout_idle got=%b/%b/%b exp=1/0/00", bus.job_ready, bus.busy, bus.mode_out); end
    checks++; if (n_start !== 1 || n_done !== 0) begin errors++; $display("FAIL timeout_pulses got=%0d starts %0d done exp=1/0", n_start, n_done); end
    tick();
  endtask

  task automatic test_skew();
    obs_t o;
    run_job(16'h4000, 16'h0020, 1'b1, o);
    checks++; if (o.et_load !== 1'b0) begin errors++; $display("FAIL skew_err_cleared got=%b exp=0", o.et_load); end
    checks++; if (o.d0 !== 50 || o.es_k !== 51) begin errors++; $display("FAIL skew_flag got=drain%0d flag%0d exp=50/51", o.d0, o.es_k); end
    checks++; if (o.r1 !== 59) begin errors++; $display("FAIL skew_not_counted got=%0d exp=59", o.r1); end
    checks++; if (o.d1 !== 107 || o.done_k !== 115 || o.n_done !== 1) begin errors++; $display("FAIL skew_done got=%0d/%0d x%0d exp=107/115 x1", o.d1, o.done_k, o.n_done); end
    checks++; if (bus.err_skew !== 1'b1) begin errors++; $display("FAIL skew_sticky got=%b exp=1", bus.err_skew); end
  endtask

  task automatic test_abort();
    int cal_due, ncal, extra;
    logic cleared;
    cal_due = -1; ncal = 0; extra = 0; cleared = 1'bx;
    bus.job_gamma = 16'h5555; bus.job_beta = 16'h6666; bus.job_valid = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    cleared = bus.err_skew;
    for (int k = 1; k < 60 && ncal < 3; k++) begin
      if (bus.start) cal_due = k + 5;
      bus.cal_done = (k == cal_due);
      if (bus.cal_done) ncal++;
      bus.abort = (ncal == 3);
      tick();
    end
    bus.cal_done = 1'b0; bus.abort = 1'b0;
    checks++; if (cleared !== 1'b0) begin errors++; $display("FAIL abort_accept_clears got=%b exp=0", cleared); end
    checks++; if (bus.busy !== 1'b0 || bus.mode_out !== 2'b00 || bus.start !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b/%b/%b exp=0/00/0", bus.busy, bus.mode_out, bus.start); end
    for (int k = 0; k < 20; k++) begin
      if (bus.start || bus.done) extra++;
      tick();
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL abort_quiet got=%0d pulses exp=0", extra); end
    bus.job_gamma = 16'h7777; bus.job_valid = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    checks++; if (bus.valid_gamma_beta !== 1'b1 || bus.gamma_out !== 16'h7777) begin errors++; $display("FAIL abort_reaccept got=%b/%h exp=1/7777", bus.valid_gamma_beta, bus.gamma_out); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++; if (bus.job_ready !== 1'b1 || bus.start !== 1'b0) begin errors++; $display("FAIL abort_in_load got=%b/%b exp=1/0", bus.job_ready, bus.start); end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = -1;
    bus.job_gamma = 16'h1234; bus.job_beta = 16'h5678;
    bus.job_valid = 1'b1; bus.cal_done = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    for (int k = 1; k < 40 && d0 < 0; k++) begin
      if (bus.mode_out == 2'b10) d0 = k;
      else tick();
    end
    bus.cal_done = 1'b0;
    checks++; if (d0 !== 18) begin errors++; $display("FAIL mid_reach_drain got=%0d exp=18", d0); end
    bus.cal_done = 1'b1; bus.job_valid = 1'b1; bus.job_gamma = 16'hBEEF;
    tick();
    bus.cal_done = 1'b0; bus.job_valid = 1'b0;
    checks++; if (bus.mode_out !== 2'b10 || bus.start !== 1'b0 || bus.gamma_out !== 16'h1234) begin errors++; $display("FAIL mid_ignored got=%b/%b/%h exp=10/0/1234", bus.mode_out, bus.start, bus.gamma_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.mode_out !== 2'b00 || bus.gamma_out !== 16'h0 || bus.mb_idx !== 2'd0 || bus.done !== 1'b0) begin errors++; $display("FAIL mid_reset got=%b/%b/%h/%0d/%b exp=0/00/0000/0/0", bus.busy, bus.mode_out, bus.gamma_out, bus.mb_idx, bus.done); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.job_ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL mid_after_reset got=%b/%b exp=1/0", bus.job_ready, bus.done); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_job();
    test_cal_held();
    test_timeout();
    test_skew();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
